// File: rtl/ram_dp_fifo_ctrl_if.sv
// Valid/ready write and read streams of the RAM-backed FIFO controller.
// The master modport is the producer/consumer side; the slave modport is the FIFO.
interface ram_dp_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/ram_dp_fifo_ctrl.sv
// FIFO controller on a dual-port synchronous RAM: port 0 writes, port 1 reads.
// A 2-entry output buffer absorbs the 1-cycle RAM read latency for full throughput.
module ram_dp_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_dp_fifo_ctrl_if.slave     fifo,
    output logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH-1:0] ram_address_0,
    output logic [DATA_WIDTH-1:0] ram_data_0,
    output logic                  ram_cs_0,
    output logic                  ram_we_0,
    output logic                  ram_oe_0,
    output logic [ADDR_WIDTH-1:0] ram_address_1,
    input  logic [DATA_WIDTH-1:0] ram_data_1,
    output logic                  ram_cs_1,
    output logic                  ram_we_1,
    output logic                  ram_oe_1
);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_r, rd_ptr_r;
    logic [ADDR_WIDTH:0]   ram_cnt_r;
    logic                  inflight_r;
    logic                  rd_en_r;
    logic [1:0]            obuf_cnt_r;
    logic [DATA_WIDTH-1:0] obuf0_r, obuf1_r;

    logic                  push_s, pop_s, issue_s, wr_ready_s;
    logic [ADDR_WIDTH:0]   ram_cnt_nxt_s;
    logic [1:0]            obuf_left_s, obuf_cnt_nxt_s;
    logic [DATA_WIDTH-1:0] obuf0_nxt_s, obuf1_nxt_s;

    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST_PTR) ? {ADDR_WIDTH{1'b0}} : p + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Handshakes, read issue decision and output-buffer next state.
    always_comb begin
        wr_ready_s    = rst_n && (ram_cnt_r != DEPTH_CNT);
        push_s        = fifo.wr_valid && wr_ready_s;
        pop_s         = (obuf_cnt_r != 2'd0) && fifo.rd_ready;
        // Issue only if the word returning next cycle is guaranteed a free buffer slot.
        issue_s       = (ram_cnt_r != {(ADDR_WIDTH+1){1'b0}}) &&
                        (({1'b0, obuf_cnt_r} + {2'b00, inflight_r}) <= (3'd1 + {2'b00, pop_s}));
        ram_cnt_nxt_s = ram_cnt_r + (ADDR_WIDTH + 1)'(push_s) - (ADDR_WIDTH + 1)'(issue_s);

        obuf0_nxt_s = obuf0_r;
        obuf1_nxt_s = obuf1_r;
        if (pop_s) begin
            obuf0_nxt_s = obuf1_r;
            obuf_left_s = obuf_cnt_r - 2'd1;
        end else begin
            obuf_left_s = obuf_cnt_r;
        end
        if (inflight_r) begin
            if (obuf_left_s == 2'd0) begin
                obuf0_nxt_s = ram_data_1;
            end else begin
                obuf1_nxt_s = ram_data_1;
            end
            obuf_cnt_nxt_s = obuf_left_s + 2'd1;
        end else begin
            obuf_cnt_nxt_s = obuf_left_s;
        end
    end

    // Pointers, occupancy, in-flight flag, output buffer and read-port enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= {ADDR_WIDTH{1'b0}};
            rd_ptr_r   <= {ADDR_WIDTH{1'b0}};
            ram_cnt_r  <= {(ADDR_WIDTH+1){1'b0}};
            inflight_r <= 1'b0;
            rd_en_r    <= 1'b0;
            obuf_cnt_r <= 2'd0;
            obuf0_r    <= {DATA_WIDTH{1'b0}};
            obuf1_r    <= {DATA_WIDTH{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (issue_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            ram_cnt_r  <= ram_cnt_nxt_s;
            inflight_r <= issue_s;
            rd_en_r    <= 1'b1;
            obuf_cnt_r <= obuf_cnt_nxt_s;
            obuf0_r    <= obuf0_nxt_s;
            obuf1_r    <= obuf1_nxt_s;
        end
    end

    // RAM port drive and stream outputs.
    always_comb begin
        fifo.wr_ready = wr_ready_s;
        fifo.rd_valid = (obuf_cnt_r != 2'd0);
        fifo.rd_data  = obuf0_r;
        count         = ram_cnt_r + (ADDR_WIDTH + 1)'(inflight_r) + (ADDR_WIDTH + 1)'(obuf_cnt_r);
        ram_cs_0      = push_s;
        ram_we_0      = push_s;
        ram_oe_0      = 1'b0;
        ram_address_0 = push_s ? wr_ptr_r : {ADDR_WIDTH{1'b0}};
        ram_data_0    = push_s ? fifo.wr_data : {DATA_WIDTH{1'b0}};
        ram_cs_1      = rd_en_r;
        ram_oe_1      = rd_en_r;
        ram_we_1      = 1'b0;
        ram_address_1 = rd_ptr_r;
    end
endmodule

// File: tb/tb_ram_dp_fifo_ctrl.sv
// Directed bench for ram_dp_fifo_ctrl with DEPTH=4 and a behavioural dual-port RAM.
module tb_ram_dp_fifo_ctrl;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DP = 4;

    logic          clk;
    logic          rst_n;
    logic [AW:0]   count;
    logic [AW-1:0] ram_address_0, ram_address_1;
    logic [DW-1:0] ram_data_0, ram_data_1;
    logic          ram_cs_0, ram_we_0, ram_oe_0, ram_cs_1, ram_we_1, ram_oe_1;

    ram_dp_fifo_ctrl_if #(.DATA_WIDTH(DW)) fif ();

    ram_dp_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP)) dut (
        .clk(clk), .rst_n(rst_n), .fifo(fif), .count(count),
        .ram_address_0(ram_address_0), .ram_data_0(ram_data_0),
        .ram_cs_0(ram_cs_0), .ram_we_0(ram_we_0), .ram_oe_0(ram_oe_0),
        .ram_address_1(ram_address_1), .ram_data_1(ram_data_1),
        .ram_cs_1(ram_cs_1), .ram_we_1(ram_we_1), .ram_oe_1(ram_oe_1)
    );

    // Dual-port synchronous RAM: registered read on port 1.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_cs_0 && ram_we_0) mem[ram_address_0] <= ram_data_0;
        if (ram_cs_1 && ram_oe_1 && !ram_we_1) ram_data_1 <= mem[ram_address_1];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [DW-1:0] exp_q [$];
    logic did_push, did_pop, prev_stall;
    logic [DW-1:0] prev_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs after the edge, sample mid-cycle, update scoreboard.
    task automatic cycle(input logic wv, input logic [DW-1:0] wd, input logic rr);
        logic [31:0] e;
        @(posedge clk); #1;
        fif.wr_valid = wv;
        fif.wr_data  = wd;
        fif.rd_ready = rr;
        #1;
        did_push = fif.wr_valid && fif.wr_ready;
        did_pop  = fif.rd_valid && fif.rd_ready;
        if (prev_stall) begin
            check_eq("stall_valid", 32'(fif.rd_valid), 32'd1);
            check_eq("stall_data", 32'(fif.rd_data), 32'(prev_data));
        end
        if (did_push) exp_q.push_back(wd);
        if (did_pop) begin
            e = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hDEAD_BEEF;
            check_eq("pop_order", 32'(fif.rd_data), e);
        end
        prev_stall = fif.rd_valid && !fif.rd_ready;
        prev_data  = fif.rd_data;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc, k, npop, first_pop, last_pop, first_push, sent, rcv, guard;
        logic got;
        prev_stall = 1'b0;
        prev_data  = '0;
        rst_n = 1'b0;
        fif.wr_valid = 1'b1;
        fif.wr_data  = 8'h55;
        fif.rd_ready = 1'b1;

        // Reset held 3 cycles with a write request pending.
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_wr_ready", 32'(fif.wr_ready), 32'd0);
        check_eq("rst_rd_valid", 32'(fif.rd_valid), 32'd0);
        check_eq("rst_rd_data", 32'(fif.rd_data), 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_cs0", 32'(ram_cs_0), 32'd0);
        check_eq("rst_we0", 32'(ram_we_0), 32'd0);
        check_eq("rst_oe0", 32'(ram_oe_0), 32'd0);
        check_eq("rst_addr0", 32'(ram_address_0), 32'd0);
        check_eq("rst_data0", 32'(ram_data_0), 32'd0);
        check_eq("rst_cs1", 32'(ram_cs_1), 32'd0);
        check_eq("rst_oe1", 32'(ram_oe_1), 32'd0);
        check_eq("rst_we1", 32'(ram_we_1), 32'd0);
        check_eq("rst_addr1", 32'(ram_address_1), 32'd0);
        fif.wr_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check_eq("rel_wr_ready", 32'(fif.wr_ready), 32'd1);
        check_eq("rel_cs1_before_edge", 32'(ram_cs_1), 32'd0);
        cycle(1'b0, 8'h00, 1'b0);
        check_eq("idle_cs1", 32'(ram_cs_1), 32'd1);
        check_eq("idle_oe1", 32'(ram_oe_1), 32'd1);
        check_eq("idle_rd_valid", 32'(fif.rd_valid), 32'd0);
        check_eq("idle_count", 32'(count), 32'd0);

        // Single word: 3-cycle latency from push to rd_valid.
        cycle(1'b1, 8'hA5, 1'b1);
        check_eq("sw_we0", 32'(ram_we_0), 32'd1);
        check_eq("sw_cs0", 32'(ram_cs_0), 32'd1);
        check_eq("sw_addr0", 32'(ram_address_0), 32'd0);
        check_eq("sw_data0", 32'(ram_data_0), 32'hA5);
        cycle(1'b0, 8'h00, 1'b1);
        check_eq("sw_t1_count", 32'(count), 32'd1);
        check_eq("sw_t1_valid", 32'(fif.rd_valid), 32'd0);
        check_eq("sw_t1_addr1", 32'(ram_address_1), 32'd0);
        cycle(1'b0, 8'h00, 1'b1);
        check_eq("sw_t2_valid", 32'(fif.rd_valid), 32'd0);
        cycle(1'b0, 8'h00, 1'b1);
        check_eq("sw_t3_valid", 32'(fif.rd_valid), 32'd1);
        check_eq("sw_t3_data", 32'(fif.rd_data), 32'hA5);
        cycle(1'b0, 8'h00, 1'b1);
        check_eq("sw_t4_valid", 32'(fif.rd_valid), 32'd0);
        check_eq("sw_t4_count", 32'(count), 32'd0);

        // Fill with consumer stalled: 4 in RAM plus 2 in the output buffer.
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 8'(i), 1'b0);
            if (did_push) acc++;
        end
        check_eq("fill_accepted", 32'(acc), 32'd6);
        check_eq("fill_wr_ready", 32'(fif.wr_ready), 32'd0);
        check_eq("fill_count", 32'(count), 32'd6);
        check_eq("fill_rd_valid", 32'(fif.rd_valid), 32'd1);
        check_eq("fill_rd_data", 32'(fif.rd_data), 32'd0);
        check_eq("fill_no_write", 32'(ram_we_0), 32'd0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 8'h00, 1'b1);
        check_eq("fill_drained", 32'(count), 32'd0);
        check_eq("fill_sb_empty", 32'(exp_q.size()), 32'd0);

        // Streaming 1..20; write pointer is at 3 here, so addresses wrap 3,0,1,...
        sent = 0; k = 0; npop = 0; first_pop = 0; last_pop = 0; first_push = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(sent < 20, 8'(sent + 1), 1'b1);
            if (did_push) begin
                if (sent == 0) first_push = cyc;
                check_eq("st_addr0", 32'(ram_address_0), 32'((3 + k) % 4));
                k++;
                sent++;
            end
            if (did_pop) begin
                if (npop == 0) first_pop = cyc;
                last_pop = cyc;
                npop++;
            end
        end
        check_eq("st_pushed", 32'(sent), 32'd20);
        check_eq("st_popped", 32'(npop), 32'd20);
        check_eq("st_latency", 32'(first_pop - first_push), 32'd3);
        check_eq("st_rate", 32'(last_pop - first_pop), 32'd19);

        // Random back-pressure, 200 words.
        sent = 0; rcv = 0; guard = 0;
        while (rcv < 200 && guard < 3000) begin
            cycle((sent < 200) && ($urandom_range(0, 1) == 1), 8'($urandom), $urandom_range(0, 1) == 1);
            if (did_push) sent++;
            if (did_pop) rcv++;
            guard++;
        end
        check_eq("bp_received", 32'(rcv), 32'd200);
        check_eq("bp_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset while a read is in flight and the head is valid.
        repeat (3) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'h11, 1'b1);
        cycle(1'b1, 8'h22, 1'b1);
        cycle(1'b1, 8'h33, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        check_eq("mr_pre_count", 32'(count), 32'd3);
        check_eq("mr_pre_valid", 32'(fif.rd_valid), 32'd1);
        check_eq("mr_pre_data", 32'(fif.rd_data), 32'h11);
        rst_n = 1'b0;
        #1;
        check_eq("mr_rd_valid", 32'(fif.rd_valid), 32'd0);
        check_eq("mr_count", 32'(count), 32'd0);
        check_eq("mr_wr_ready", 32'(fif.wr_ready), 32'd0);
        exp_q.delete();
        prev_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cycle(1'b1, 8'h3C, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            if (did_pop && !got) begin
                check_eq("mr_first_word", 32'(fif.rd_data), 32'h3C);
                got = 1'b1;
            end
        end
        check_eq("mr_got_word", 32'(got), 32'd1);
        check_eq("mr_final_count", 32'(count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ram_dp_fifo_ctrl.md
# ram_dp_fifo_ctrl

Synchronous FIFO controller that uses the team's dual-port synchronous RAM as storage: port 0 is the write port, port 1 the read port. It turns a valid/ready write stream into RAM port-0 write cycles and RAM port-1 registered reads back into a valid/ready read stream. A 2-entry output buffer hides the RAM's 1-cycle read latency so the FIFO sustains one word per clock.

## Interface
- DATA_WIDTH, 8, word width; must equal the RAM data width.
- ADDR_WIDTH, 16, RAM address width.
- DEPTH, 256, RAM words used; 2 ≤ DEPTH ≤ 2^ADDR_WIDTH; power of two not required.
- clk  in  1  single clock, all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  space available.
- wr_data  in  DATA_WIDTH  write word.
- rd_valid  out  1  head word available.
- rd_ready  in  1  consumer accepts head.
- rd_data  out  DATA_WIDTH  head word.
- count  out  ADDR_WIDTH+1  total words held (RAM + in-flight + output buffer).
- ram_address_0, ram_data_0  out  ADDR_WIDTH, DATA_WIDTH  port-0 address / write data.
- ram_cs_0, ram_we_0, ram_oe_0  out  1  port-0 controls.
- ram_address_1  out  ADDR_WIDTH  port-1 address.
- ram_data_1  in  DATA_WIDTH  port-1 read data.
- ram_cs_1, ram_we_1, ram_oe_1  out  1  port-1 controls.

## Operation
- State: wr_ptr, rd_ptr (0..DEPTH-1, wrap DEPTH-1→0), ram_cnt (0..DEPTH), inflight (0/1), 2-entry output buffer obuf with obuf_cnt (0..2).
- push = wr_valid && wr_ready; wr_ready = rst_n && (ram_cnt != DEPTH), combinational.
- Write: on push, same cycle, ram_cs_0=1, ram_we_0=1, ram_address_0=wr_ptr, ram_data_0=wr_data; else cs_0=we_0=0, address/data 0. ram_oe_0 always 0. wr_ptr advances at edge.
- Read port: ram_cs_1=ram_oe_1 registered, 0 in reset, 1 from first edge after reset release; ram_we_1 always 0. Keeping port 1 permanently enabled makes ram_data_1 in cycle t+1 equal mem[ram_address_1 during cycle t].
- pop = rd_valid && rd_ready.
- Issue: issue = (ram_cnt != 0) && (obuf_cnt + inflight − pop ≤ 1). On issue, ram_address_1=rd_ptr; rd_ptr advances; inflight_next = issue. When no issue, ram_address_1 holds rd_ptr.
- Capture: when inflight=1, ram_data_1 is written into obuf at the edge (behind the current head, or as head if the head is popped or obuf is empty).
- ram_cnt_next = ram_cnt + push − issue; count = ram_cnt + inflight + obuf_cnt; max count DEPTH+2.
- rd_valid = (obuf_cnt != 0); rd_data = obuf head; rd_data held stable while rd_valid && !rd_ready.
- Hazard: a word written in cycle t is counted in ram_cnt from t+1, so it is read no earlier than t+1, after the RAM committed it. No bypass is needed.
- Full: push ignored when wr_ready=0 (no RAM write, no pointer change). Empty: rd_valid=0; rd_ready is ignored.
- Simultaneous push and issue at ram_cnt=DEPTH: wr_ready stays 0 that cycle. wr_ready is not lookahead.
- Reset (any time, mid-transfer): pointers, counts, inflight, obuf cleared; any in-flight read is discarded; RAM contents are left stale and are never observed.

## Timing
- Reset values: wr_ready 0 while rst_n low, 1 after; rd_valid 0; rd_data 0; count 0; ram_cs_0/we_0/oe_0 0; ram_address_0/ram_data_0 0; ram_cs_1/oe_1/we_1 0; ram_address_1 0.
- Empty-FIFO latency: push in cycle t → issue t+1 → ram_data_1 valid t+2 → rd_valid=1 in t+3.
- Throughput: 1 push and 1 pop per cycle sustained once obuf holds 1 word.
- rd_ready low: obuf fills to 2, then issues stop and ram_cnt accumulates. wr_ready drops after DEPTH further writes.

## Test plan
- Reset then idle: rst_n low 3 cycles → all outputs at reset values; after release wr_ready=1, ram_cs_1=ram_oe_1=1, rd_valid=0, count=0.
- Single word: push 0xA5 at cycle t, rd_ready=1 → ram_we_0=1 at address 0 in t; rd_valid with rd_data=0xA5 in t+3; count returns to 0.
- Fill: DEPTH=4, rd_ready=0, push 0..9 every cycle → exactly 6 accepted (4 RAM + 2 obuf); wr_ready=0, count=6; rd_data=0 held.
- Streaming with wrap: DEPTH=4, push 1..20 back-to-back, rd_ready=1 → output 1..20 in order, one per cycle after 3-cycle latency; addresses wrap 3→0.
- Back-pressure: random rd_ready at 50% duty, 200 words → no loss, duplication or reorder; rd_data stable while stalled.
- Mid-stream reset: assert rst_n low during streaming with inflight=1 → rd_valid=0 and count=0 immediately; next push 0x3C is read back as the first word.
